// File: rtl/serial_frame_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
// Parity build option: SERIAL_FRAME_TX_PARITY_EN.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        STOP = 3'd4
    } state_t;

    localparam logic STOP_LVL = 1'b0;
    localparam logic IDLE_LVL = 1'b0;

    // Legal ranges: WIDTH 1..32, PRE_LEN 1..8.
    function automatic bit params_ok(input int unsigned width, input int unsigned pre_len);
        return (width >= 1) && (width <= 32) && (pre_len >= 1) && (pre_len <= 8);
    endfunction

    // Counter must hold the longer of the preamble and data phases.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned pre_len);
        int unsigned m;
        m = (width > pre_len) ? width : pre_len;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/serial_frame_tx_shreg.sv
// Loadable MSB-first shift register holding the word being transmitted.
// Used by serial_frame_tx in both parity (SERIAL_FRAME_TX_PARITY_EN) and plain builds.
module serial_frame_tx_shreg
    import serial_frame_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

    assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble, data MSB-first, optional parity, stop.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit after the data.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PRE_LEN     = 2,
    parameter logic [7:0]  PRE_PATTERN = 8'h02
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Load_Valid,
    output logic             Load_Ready,
    input  logic [WIDTH-1:0] Load_Data,
    output logic             Ser_Out,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = cnt_width(WIDTH, PRE_LEN);
    localparam logic [PRE_LEN-1:0] PRE_BITS = PRE_PATTERN[PRE_LEN-1:0];

    if (!params_ok(WIDTH, PRE_LEN)) begin : g_param_check
        $error("serial_frame_tx: WIDTH must be 1..32 and PRE_LEN 1..8");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [PRE_LEN-1:0] pre_q;
    logic               sr_msb;
    logic               accept_c;
    logic               last_c;
    logic               shift_c;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic               par_q;
`endif

    assign accept_c = Load_Valid & Load_Ready;
    assign last_c   = (cnt == CNT_W'(1));
    // Advance the word each time its current MSB is launched onto the line.
    assign shift_c  = ((state == PRE) && last_c) || ((state == DATA) && !last_c);

    serial_frame_tx_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .CLK   (CLK),
        .RST   (RST),
        .load  (accept_c),
        .shift (shift_c),
        .din   (Load_Data),
        .msb   (sr_msb)
    );

    // Outputs are set on the edge that enters each state, so they line up with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            pre_q      <= '0;
            Ser_Out    <= IDLE_LVL;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Load_Ready <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state      <= PRE;
                        cnt        <= CNT_W'(PRE_LEN);
                        Ser_Out    <= PRE_BITS[PRE_LEN-1];
                        pre_q      <= PRE_BITS << 1;
                        Busy       <= 1'b1;
                        Load_Ready <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        par_q      <= ^Load_Data;
`endif
                    end
                end
                PRE: begin
                    if (last_c) begin
                        state   <= DATA;
                        cnt     <= CNT_W'(WIDTH);
                        Ser_Out <= sr_msb;
                    end else begin
                        cnt     <= cnt - CNT_W'(1);
                        Ser_Out <= pre_q[PRE_LEN-1];
                        pre_q   <= pre_q << 1;
                    end
                end
                DATA: begin
                    if (last_c) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state   <= PAR;
                        cnt     <= CNT_W'(1);
                        Ser_Out <= par_q;
`else
                        state   <= STOP;
                        cnt     <= CNT_W'(1);
                        Ser_Out <= STOP_LVL;
                        Done    <= 1'b1;
`endif
                    end else begin
                        cnt     <= cnt - CNT_W'(1);
                        Ser_Out <= sr_msb;
                    end
                end
                PAR: begin
                    state   <= STOP;
                    cnt     <= CNT_W'(1);
                    Ser_Out <= STOP_LVL;
                    Done    <= 1'b1;
                end
                STOP: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    Ser_Out    <= IDLE_LVL;
                    Busy       <= 1'b0;
                    Done       <= 1'b0;
                    Load_Ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    Ser_Out    <= IDLE_LVL;
                    Busy       <= 1'b0;
                    Done       <= 1'b0;
                    Load_Ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
